// File: rtl/mips_trace_pkg.sv
// Shared definitions for the commit-trace unit: capture modes, FSM
// encodings and the layout of one trace record.
package mips_trace_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_ALL    = 2'd1;
    localparam logic [1:0] MODE_WRITES = 2'd2;
    localparam logic [1:0] MODE_TRIG   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } trace_state_t;

    // Record layout, LSB first: dm_wdata, dm_addr, gpr_wdata, gpr_addr, d, g, pc
    function automatic int rec_w(int pc_w, int ra_w, int dm_aw, int data_w);
        return pc_w + 2 + ra_w + dm_aw + 2 * data_w;
    endfunction

    function automatic int off_dm_addr(int data_w);
        return data_w;
    endfunction

    function automatic int off_gpr_wdata(int data_w, int dm_aw);
        return data_w + dm_aw;
    endfunction

    function automatic int off_gpr_addr(int data_w, int dm_aw);
        return 2 * data_w + dm_aw;
    endfunction

    function automatic int off_d(int data_w, int dm_aw, int ra_w);
        return 2 * data_w + dm_aw + ra_w;
    endfunction

    function automatic int off_g(int data_w, int dm_aw, int ra_w);
        return off_d(data_w, dm_aw, ra_w) + 1;
    endfunction

    function automatic int off_pc(int data_w, int dm_aw, int ra_w);
        return off_d(data_w, dm_aw, ra_w) + 2;
    endfunction

endpackage

// File: rtl/mips_trace_unit_fifo.sv
// Synchronous FIFO for trace records. The head entry is held in an output
// register so the consumer sees a registered, stable record; a push into
// the slot that is about to become the head is forwarded into that register.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   level_reg;
    logic [W-1:0]  dout_reg;
    logic          push_ok, pop_ok;

    // Handshake qualification; a pop frees a slot for a same-cycle push
    always_comb begin
        full        = (level_reg == LVL_FULL);
        empty       = (level_reg == '0);
        pop_ok      = pop && !empty;
        push_ok     = push && (!full || pop_ok);
        rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointers, occupancy and the registered head entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok && !pop_ok)
                level_reg <= level_reg + (AW + 1)'(1);
            else if (pop_ok && !push_ok)
                level_reg <= level_reg - (AW + 1)'(1);
            if (push_ok || pop_ok)
                dout_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data
                                                                     : mem[rd_ptr_next];
        end
    end

    assign pop_data = dout_reg;
    assign level    = level_reg;

endmodule

// File: rtl/mips_trace_unit.sv
// Commit-trace capture unit: filters retiring instructions, optionally waits
// for a trigger PC, and queues bounded trace records for a valid/ready drain.
module mips_trace_unit
    import mips_trace_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int RA_W       = 5,
    parameter int DM_AW      = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  commit,
    input  logic [PC_W-1:0]                       commit_pc,
    input  logic                                  gpr_we,
    input  logic [RA_W-1:0]                       gpr_addr,
    input  logic [DATA_W-1:0]                     gpr_wdata,
    input  logic                                  dm_we,
    input  logic [DM_AW-1:0]                      dm_addr,
    input  logic [DATA_W-1:0]                     dm_wdata,
    input  logic [1:0]                            cfg_mode,
    input  logic [PC_W-1:0]                       cfg_trig_pc,
    input  logic [CNT_W-1:0]                      cfg_count,
    input  logic                                  cfg_arm,
    input  logic                                  cfg_stop,
    output logic                                  trace_valid,
    input  logic                                  trace_ready,
    output logic [PC_W+2+RA_W+DM_AW+2*DATA_W-1:0] trace_data,
    output logic [2:0]                            state,
    output logic [CNT_W-1:0]                      drop_cnt,
    output logic                                  overflow,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);
    localparam int REC_W = rec_w(PC_W, RA_W, DM_AW, DATA_W);
    localparam int O_DMA = off_dm_addr(DATA_W);
    localparam int O_GW  = off_gpr_wdata(DATA_W, DM_AW);
    localparam int O_GA  = off_gpr_addr(DATA_W, DM_AW);
    localparam int O_D   = off_d(DATA_W, DM_AW, RA_W);
    localparam int O_G   = off_g(DATA_W, DM_AW, RA_W);
    localparam int O_PC  = off_pc(DATA_W, DM_AW, RA_W);

    trace_state_t     state_reg;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] cap_cnt_reg, cap_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic             overflow_reg;

    logic             g, d, trig_hit, cap_event, hit_limit, pop, fifo_full, fifo_empty;
    logic [REC_W-1:0] rec;

    // Event qualification and record assembly; unused fields stay zero
    always_comb begin
        g            = gpr_we && (gpr_addr != '0);
        d            = dm_we;
        trig_hit     = (state_reg == ST_ARMED) && commit && (commit_pc == cfg_trig_pc);
        cap_event    = trig_hit ||
                       (((state_reg == ST_RUN) || (state_reg == ST_CAPTURE)) && commit &&
                        ((mode_reg != MODE_WRITES) || g || d));
        cap_cnt_next = cap_cnt_reg + CNT_W'(1);
        hit_limit    = (cfg_count != '0) && (cap_cnt_next == cfg_count);
        rec                    = '0;
        rec[0 +: DATA_W]       = d ? dm_wdata : '0;
        rec[O_DMA +: DM_AW]    = d ? dm_addr : '0;
        rec[O_GW +: DATA_W]    = g ? gpr_wdata : '0;
        rec[O_GA +: RA_W]      = g ? gpr_addr : '0;
        rec[O_D]               = d;
        rec[O_G]               = g;
        rec[O_PC +: PC_W]      = commit_pc;
    end

    // Capture FSM: arming, trigger, length limit; stop overrides everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= MODE_OFF;
            cap_cnt_reg <= '0;
        end else if (cfg_stop) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (cfg_arm) begin
                        mode_reg    <= cfg_mode;
                        cap_cnt_reg <= '0;
                        if ((cfg_mode == MODE_ALL) || (cfg_mode == MODE_WRITES))
                            state_reg <= ST_RUN;
                        else if (cfg_mode == MODE_TRIG)
                            state_reg <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        cap_cnt_reg <= cap_cnt_next;
                        state_reg   <= hit_limit ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_RUN, ST_CAPTURE: begin
                    if (cap_event) begin
                        cap_cnt_reg <= cap_cnt_next;
                        if (hit_limit)
                            state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Loss accounting: a push into a full FIFO with no pop is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (cap_event && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != '1)
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
        end
    end

    assign pop         = trace_valid && trace_ready;
    assign trace_valid = !fifo_empty;
    assign state       = state_reg;
    assign drop_cnt    = drop_cnt_reg;
    assign overflow    = overflow_reg;

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_event),
        .push_data (rec),
        .pop       (pop),
        .pop_data  (trace_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_mips_trace_unit.sv
// Directed bench for mips_trace_unit with a 4-entry FIFO.
module tb_mips_trace_unit;
    localparam int REC_W = 113;

    logic              clk = 1'b0;
    logic              rst;
    logic              commit;
    logic [31:0]       commit_pc;
    logic              gpr_we;
    logic [4:0]        gpr_addr;
    logic [31:0]       gpr_wdata;
    logic              dm_we;
    logic [9:0]        dm_addr;
    logic [31:0]       dm_wdata;
    logic [1:0]        cfg_mode;
    logic [31:0]       cfg_trig_pc;
    logic [15:0]       cfg_count;
    logic              cfg_arm;
    logic              cfg_stop;
    logic              trace_valid;
    logic              trace_ready;
    logic [REC_W-1:0]  trace_data;
    logic [2:0]        state;
    logic [15:0]       drop_cnt;
    logic              overflow;
    logic [2:0]        fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_trace_unit #(
        .DATA_W(32), .PC_W(32), .RA_W(5), .DM_AW(10), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc),
        .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_wdata(gpr_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .cfg_mode(cfg_mode), .cfg_trig_pc(cfg_trig_pc), .cfg_count(cfg_count),
        .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .state(state), .drop_cnt(drop_cnt), .overflow(overflow), .fifo_level(fifo_level)
    );

    function automatic logic [REC_W-1:0] rec(logic [31:0] pc, logic g, logic d,
                                             logic [4:0] ga, logic [31:0] gw,
                                             logic [9:0] da, logic [31:0] dw);
        return {pc, g, d, ga, gw, da, dw};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(logic [1:0] mode, logic [15:0] cnt, logic [31:0] trig);
        cfg_mode = mode; cfg_count = cnt; cfg_trig_pc = trig; cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        $display("arm mode=%0d count=%0d trig=%0h -> state=%0d", mode, cnt, trig, state);
    endtask

    task automatic do_commit(logic [31:0] pc, logic gwe, logic [4:0] ga, logic [31:0] gw,
                             logic dwe, logic [9:0] da, logic [31:0] dw);
        commit = 1'b1; commit_pc = pc;
        gpr_we = gwe; gpr_addr = ga; gpr_wdata = gw;
        dm_we = dwe; dm_addr = da; dm_wdata = dw;
        tick();
        commit = 1'b0; gpr_we = 1'b0; dm_we = 1'b0;
        gpr_addr = '0; gpr_wdata = '0; dm_addr = '0; dm_wdata = '0;
        $display("commit pc=%0h -> state=%0d level=%0d drop=%0d", pc, state, fifo_level, drop_cnt);
    endtask

    task automatic pop_chk(string tag, logic [REC_W-1:0] exp);
        chk({tag, "_valid"}, trace_valid, 1);
        chk({tag, "_data"}, trace_data, exp);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        $display("pop %s pc=%0h", tag, exp[REC_W-1 -: 32]);
    endtask

    initial begin
        rst = 1'b0; commit = 0; commit_pc = 0; gpr_we = 0; gpr_addr = 0; gpr_wdata = 0;
        dm_we = 0; dm_addr = 0; dm_wdata = 0; cfg_mode = 0; cfg_trig_pc = 0; cfg_count = 0;
        cfg_arm = 0; cfg_stop = 0; trace_ready = 0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_data", trace_data, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        tick();

        // Mode 1, limit 4, six commits
        arm(2'd1, 16'd4, 32'h0);
        chk("m1_state_run", state, 1);
        commit = 1'b1; commit_pc = 32'h0;
        #1;
        chk("m1_no_bypass", trace_valid, 0);
        tick();
        commit = 1'b0;
        chk("m1_valid_next", trace_valid, 1);
        do_commit(32'h4, 0, 0, 0, 0, 0, 0);
        do_commit(32'h8, 0, 0, 0, 0, 0, 0);
        chk("m1_state_run3", state, 1);
        do_commit(32'hC, 0, 0, 0, 0, 0, 0);
        chk("m1_state_done", state, 4);
        do_commit(32'h10, 0, 0, 0, 0, 0, 0);
        do_commit(32'h14, 0, 0, 0, 0, 0, 0);
        chk("m1_level", fifo_level, 4);
        chk("m1_drop", drop_cnt, 0);
        pop_chk("m1_r0", rec(32'h0, 0, 0, 0, 0, 0, 0));
        pop_chk("m1_r1", rec(32'h4, 0, 0, 0, 0, 0, 0));
        pop_chk("m1_r2", rec(32'h8, 0, 0, 0, 0, 0, 0));
        pop_chk("m1_r3", rec(32'hC, 0, 0, 0, 0, 0, 0));
        chk("m1_empty", trace_valid, 0);
        chk("m1_level0", fifo_level, 0);

        // Mode 2, unbounded, writes only
        arm(2'd2, 16'd0, 32'h0);
        chk("m2_state", state, 1);
        do_commit(32'h40, 1, 5'd8, 32'h1234, 0, 0, 0);
        do_commit(32'h44, 0, 0, 0, 1, 10'd3, 32'h55);
        do_commit(32'h48, 0, 0, 0, 0, 0, 0);
        do_commit(32'h4C, 1, 5'd0, 32'hDEAD, 0, 0, 0);
        chk("m2_level", fifo_level, 2);
        pop_chk("m2_r0", rec(32'h40, 1, 0, 5'd8, 32'h1234, 0, 0));
        pop_chk("m2_r1", rec(32'h44, 0, 1, 0, 0, 10'd3, 32'h55));
        cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
        chk("m2_stop", state, 0);

        // Mode 3, trigger 0x20, limit 2
        arm(2'd3, 16'd2, 32'h20);
        chk("m3_armed", state, 2);
        do_commit(32'h18, 0, 0, 0, 0, 0, 0);
        do_commit(32'h1C, 0, 0, 0, 0, 0, 0);
        chk("m3_still_armed", state, 2);
        chk("m3_level_pre", fifo_level, 0);
        do_commit(32'h20, 0, 0, 0, 0, 0, 0);
        chk("m3_capture", state, 3);
        do_commit(32'h24, 0, 0, 0, 0, 0, 0);
        chk("m3_done", state, 4);
        do_commit(32'h28, 0, 0, 0, 0, 0, 0);
        chk("m3_level", fifo_level, 2);
        pop_chk("m3_r0", rec(32'h20, 0, 0, 0, 0, 0, 0));
        pop_chk("m3_r1", rec(32'h24, 0, 0, 0, 0, 0, 0));

        // Overflow: 7 commits into 4 entries, then pop+push while full
        arm(2'd1, 16'd0, 32'h0);
        for (int i = 0; i < 7; i++)
            do_commit(32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
        chk("ov_level", fifo_level, 4);
        chk("ov_drop", drop_cnt, 3);
        chk("ov_flag", overflow, 1);
        commit = 1'b1; commit_pc = 32'h200; trace_ready = 1'b1;
        chk("ov_head", trace_data, rec(32'h100, 0, 0, 0, 0, 0, 0));
        tick();
        commit = 1'b0; trace_ready = 1'b0;
        chk("ov_level_keep", fifo_level, 4);
        chk("ov_drop_keep", drop_cnt, 3);
        pop_chk("ov_r1", rec(32'h104, 0, 0, 0, 0, 0, 0));
        pop_chk("ov_r2", rec(32'h108, 0, 0, 0, 0, 0, 0));
        pop_chk("ov_r3", rec(32'h10C, 0, 0, 0, 0, 0, 0));
        pop_chk("ov_r4", rec(32'h200, 0, 0, 0, 0, 0, 0));
        chk("ov_sticky", overflow, 1);

        // Stop, then arm and stop together in IDLE
        cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
        chk("st_idle", state, 0);
        cfg_mode = 2'd1; cfg_count = 0; cfg_arm = 1'b1; cfg_stop = 1'b1;
        tick();
        cfg_arm = 1'b0; cfg_stop = 1'b0;
        chk("as_idle", state, 0);
        do_commit(32'h300, 0, 0, 0, 0, 0, 0);
        chk("as_level", fifo_level, 0);
        chk("as_valid", trace_valid, 0);

        // Single-entry pop+push: new record becomes head
        arm(2'd1, 16'd0, 32'h0);
        do_commit(32'h400, 0, 0, 0, 0, 0, 0);
        commit = 1'b1; commit_pc = 32'h404; trace_ready = 1'b1;
        chk("fw_head", trace_data, rec(32'h400, 0, 0, 0, 0, 0, 0));
        tick();
        commit = 1'b0; trace_ready = 1'b0;
        chk("fw_level", fifo_level, 1);
        chk("fw_data", trace_data, rec(32'h404, 0, 0, 0, 0, 0, 0));
        do_commit(32'h408, 0, 0, 0, 0, 0, 0);
        do_commit(32'h40C, 0, 0, 0, 0, 0, 0);
        chk("mr_level3", fifo_level, 3);
        chk("mr_run", state, 1);

        // Asynchronous reset mid-capture
        rst = 1'b0;
        #2;
        chk("mr_state", state, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_valid", trace_valid, 0);
        chk("mr_data", trace_data, 0);
        chk("mr_drop", drop_cnt, 0);
        chk("mr_ovf", overflow, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
